// File: rtl/gyr_light_monitor.sv
// Passive checker for the G->Y->R lamp sequence: one-hot, order and dwell checks.
// Optional macro GYR_MON_ERR_CNT_EN implements the saturating err_cnt counter; otherwise err_cnt is 0.
module gyr_light_monitor #(
    parameter int unsigned GREEN_CYC  = 1000,
    parameter int unsigned YELLOW_CYC = 200,
    parameter int unsigned RED_CYC    = 800,
    parameter int unsigned TOL        = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        green,
    input  logic        yellow,
    input  logic        red,
    output logic [1:0]  phase,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [7:0]  err_cnt,
    output logic [15:0] rounds
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } state_t;

    localparam logic [23:0] G_LO = 24'(GREEN_CYC - TOL);
    localparam logic [23:0] G_HI = 24'(GREEN_CYC + TOL + 1);
    localparam logic [23:0] Y_LO = 24'(YELLOW_CYC - TOL);
    localparam logic [23:0] Y_HI = 24'(YELLOW_CYC + TOL + 1);
    localparam logic [23:0] R_LO = 24'(RED_CYC - TOL);
    localparam logic [23:0] R_HI = 24'(RED_CYC + TOL + 1);

    state_t      state;
    logic [23:0] dwell;
    logic        chk;
    logic        long_done;

    state_t      obs;
    state_t      nxt;
    logic [23:0] dwell_inc;
    logic [23:0] lo;
    logic [23:0] hi;
    logic [2:0]  ev;

    always_comb begin
        obs = IDLE;
        case ({green, yellow, red})
            3'b100:  obs = GREEN;
            3'b010:  obs = YELLOW;
            3'b001:  obs = RED;
            default: obs = IDLE;
        endcase

        nxt = IDLE;
        lo  = '0;
        hi  = '1;
        case (state)
            GREEN:   begin nxt = YELLOW; lo = G_LO; hi = G_HI; end
            YELLOW:  begin nxt = RED;    lo = Y_LO; hi = Y_HI; end
            RED:     begin nxt = GREEN;  lo = R_LO; hi = R_HI; end
            default: begin nxt = IDLE;   lo = '0;   hi = '1;   end
        endcase

        dwell_inc = (dwell == '1) ? dwell : dwell + 24'd1;

        // Branches are mutually exclusive, so the 1>2>3>4 priority falls out naturally
        ev = 3'd0;
        if (state != IDLE) begin
            if (obs == IDLE)
                ev = 3'd1;
            else if (obs == state) begin
                if (chk && !long_done && dwell_inc >= hi)
                    ev = 3'd4;
            end else if (obs == nxt) begin
                if (chk && dwell < lo)
                    ev = 3'd3;
            end else
                ev = 3'd2;
        end
    end

    assign phase = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            dwell     <= '0;
            chk       <= 1'b0;
            long_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            rounds    <= '0;
        end else begin
            if (state == IDLE) begin
                if (obs != IDLE) begin
                    state     <= obs;
                    dwell     <= 24'd1;
                    chk       <= 1'b0;
                    long_done <= 1'b0;
                end
            end else if (obs == IDLE) begin
                state     <= IDLE;
                dwell     <= '0;
                chk       <= 1'b0;
                long_done <= 1'b0;
            end else if (obs == state) begin
                dwell <= dwell_inc;
                if (ev == 3'd4)
                    long_done <= 1'b1;
            end else begin
                state     <= obs;
                dwell     <= 24'd1;
                chk       <= (obs == nxt);
                long_done <= 1'b0;
                if (obs == nxt && state == RED)
                    rounds <= rounds + 16'd1;
            end

            if (ev != 3'd0) begin
                err <= 1'b1;
                if (err_code == 3'd0)
                    err_code <= ev;
            end
        end
    end

`ifdef GYR_MON_ERR_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_cnt <= '0;
        else if (ev != 3'd0 && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule
